// File: rtl/gbuff_reader_pkg.sv
// Shared gbuff reader definitions: address/word widths, gbuff address window and FSM encodings.
// The optional stall counter is enabled with GBUFF_READER_STALL_CNT_EN.
`ifndef GBUFF_READER_DEFS
`define GBUFF_READER_DEFS
`define ADDR_WIDTH        8
`define WORD_WIDTH        16
`define GBUFF_ADDR_BEGIN  8'h08
`define GBUFF_ADDR_END    8'hF7
`define STATE_IDLE        2'd0
`define STATE_READ        2'd1
`define STATE_DRAIN       2'd2
`endif

package gbuff_reader_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int WORD_W = `WORD_WIDTH;
  localparam logic [ADDR_W-1:0] GB_BEGIN = `GBUFF_ADDR_BEGIN;
  localparam logic [ADDR_W-1:0] GB_END   = `GBUFF_ADDR_END;

  typedef enum logic [1:0] {
    ST_IDLE  = `STATE_IDLE,
    ST_READ  = `STATE_READ,
    ST_DRAIN = `STATE_DRAIN
  } state_e;

  // Successor address inside the circular gbuff window.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == GB_END) ? GB_BEGIN : a + 1'b1;
  endfunction

endpackage

// File: rtl/gbuff_rd_fifo.sv
// Small skid FIFO holding gbuff read data until the stream consumer accepts it.
module gbuff_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gbuff_reader.sv
// Burst reader: streams len words from the gbuff into a ready/valid feeder port.
// Defining GBUFF_READER_STALL_CNT_EN adds the stall_cnt_o back-pressure counter.
module gbuff_reader
  import gbuff_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              gb_en_o,
  output logic              gb_we_o,
  output logic [ADDR_W-1:0] gb_addr_o,
  input  logic [WORD_W-1:0] gb_rdata_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef GBUFF_READER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_e            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   issue_rem_reg;
  logic [ADDR_W:0]   xfer_rem_reg;
  logic              pend_reg;
  logic              done_reg;

  logic              start_ok;
  logic              pop;
  logic              credit;
  logic              read_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign start_ok = (state_reg == ST_IDLE) && start_i && (len_i != '0);
  assign pop      = valid_o && ready_i;
  // A word leaving this cycle frees its slot for a new read, which keeps one word per cycle.
  assign credit   = (32'(fifo_count) + 32'(pend_reg)) < (32'(FIFO_DEPTH) + 32'(pop));
  assign read_en  = start_ok ||
                    ((state_reg == ST_READ) && credit && (!fifo_full || pop));

  assign gb_en_o   = read_en;
  assign gb_we_o   = 1'b0;
  assign gb_addr_o = start_ok ? base_addr_i : addr_reg;
  assign valid_o   = !fifo_empty;
  assign busy_o    = (state_reg != ST_IDLE);
  assign done_o    = done_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      issue_rem_reg <= '0;
      xfer_rem_reg  <= '0;
      pend_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      pend_reg <= read_en;
      if (read_en) begin
        addr_reg <= next_addr(gb_addr_o);
      end
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_reg <= 1'b1;
            end else begin
              // The first read already issues in this cycle.
              issue_rem_reg <= len_i - LEN_ONE;
              xfer_rem_reg  <= len_i;
              state_reg     <= (len_i == LEN_ONE) ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (read_en) begin
            issue_rem_reg <= issue_rem_reg - LEN_ONE;
            if (issue_rem_reg == LEN_ONE) begin
              state_reg <= ST_DRAIN;
            end
          end
          if (pop) begin
            xfer_rem_reg <= xfer_rem_reg - LEN_ONE;
          end
        end
        ST_DRAIN: begin
          if (pop) begin
            xfer_rem_reg <= xfer_rem_reg - LEN_ONE;
            if (xfer_rem_reg == LEN_ONE) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  gbuff_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (pend_reg),
    .pop_i   (pop),
    .din_i   (gb_rdata_i),
    .dout_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef GBUFF_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || ((state_reg == ST_IDLE) && start_i)) begin
      stall_cnt_reg <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_gbuff_reader.sv
// Directed bench for gbuff_reader with a gbuff memory model and address/data scoreboards.
module tb_gbuff_reader;
  import gbuff_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   len_i;
  logic              gb_en_o;
  logic              gb_we_o;
  logic [ADDR_W-1:0] gb_addr_o;
  logic [WORD_W-1:0] gb_rdata_i;
  logic [WORD_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic              done_o;
`ifdef GBUFF_READER_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [WORD_W-1:0] exp_data_q[$];
  logic [WORD_W-1:0] mem [1<<ADDR_W];

  gbuff_reader #(.FIFO_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .gb_en_o     (gb_en_o),
    .gb_we_o     (gb_we_o),
    .gb_addr_o   (gb_addr_o),
    .gb_rdata_i  (gb_rdata_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef GBUFF_READER_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  function automatic logic [WORD_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return WORD_W'((int'(a) * 257) ^ 32'h5A3C);
  endfunction

  // gbuff model: registered read, data valid the cycle after the enable.
  always @(posedge clk) begin
    if (gb_en_o) gb_rdata_i <= mem[gb_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issued read and every transferred word is matched in order.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (gb_en_o) begin
        check("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check("rd_addr", 32'(gb_addr_o), 32'(exp_addr_q.pop_front()));
      end
      if (valid_o && ready_i) begin
        check("xfer_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) check("xfer_data", 32'(data_o), 32'(exp_data_q.pop_front()));
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [ADDR_W-1:0] a);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(word_at(a));
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    a = b;
    for (int i = 0; i < n; i++) begin
      expect_word(a);
      a = (a == GB_END) ? GB_BEGIN : a + 1'b1;
    end
  endtask

  task automatic launch(input logic [ADDR_W-1:0] b, input int n);
    base_addr_i = b;
    len_i       = (ADDR_W+1)'(n);
    start_i     = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else tick();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(gb_en_o),   32'd0);
    check({tag, "_we"},    32'(gb_we_o),   32'd0);
    check({tag, "_addr"},  32'(gb_addr_o), 32'd0);
    check({tag, "_valid"}, 32'(valid_o),   32'd0);
    check({tag, "_busy"},  32'(busy_o),    32'd0);
    check({tag, "_done"},  32'(done_o),    32'd0);
    check({tag, "_data"},  32'(data_o),    32'd0);
`ifdef GBUFF_READER_STALL_CNT_EN
    check({tag, "_stall"}, stall_cnt_o,    32'd0);
`endif
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_data_left"}, 32'(exp_data_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = word_at(ADDR_W'(i));
    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1; base_addr_i = '0; len_i = '0;
    tick(); tick(); tick();
    @(negedge clk);
    check_reset_outputs("reset");
    $display("reset: outputs checked");
    tick();
    rst_i = 1'b0;

    // Burst of 4 from 0x10, consumer always ready.
    tick();
    push_burst(8'h10, 4);
    d0 = done_cnt;
    launch(8'h10, 4);
    @(negedge clk);
    check("t1_c0_en", 32'(gb_en_o), 32'd1);
    check("t1_c0_busy", 32'(busy_o), 32'd0);
    tick(); start_i = 1'b0;
    @(negedge clk);
    check("t1_c1_valid", 32'(valid_o), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      @(negedge clk);
      check("t1_stream_valid", 32'(valid_o), 32'd1);
    end
    tick();
    @(negedge clk);
    check("t1_done_pulse", 32'(done_o), 32'd1);
    check("t1_valid_after", 32'(valid_o), 32'd0);
    tick();
    @(negedge clk);
    check("t1_done_low", 32'(done_o), 32'd0);
    check("t1_busy_low", 32'(busy_o), 32'd0);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);
    check_queues("t1");
    $display("burst base=10 len=4: done");

    // Burst of 6 with the consumer stalled in cycles 2..5.
    tick();
    push_burst(8'h40, 6);
    d0 = done_cnt;
    launch(8'h40, 6);
    tick(); start_i = 1'b0;
    tick(); ready_i = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      check("t2_stall_valid", 32'(valid_o), 32'd1);
      check("t2_stall_data", 32'(data_o), 32'(word_at(8'h40)));
      check("t2_stall_no_read", 32'(gb_en_o), 32'd0);
      tick();
    end
    ready_i = 1'b1;
    wait_done(40, "t2_done_seen");
    tick();
    @(negedge clk);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);
    check_queues("t2");
`ifdef GBUFF_READER_STALL_CNT_EN
    check("t2_stall_cnt", stall_cnt_o, 32'd4);
`endif
    $display("burst base=40 len=6 stalled: done");

    // Burst across the end of the gbuff window.
    tick();
    expect_word(GB_END - 8'd1);
    expect_word(GB_END);
    expect_word(GB_BEGIN);
    launch(GB_END - 8'd1, 3);
    tick(); start_i = 1'b0;
    wait_done(20, "t3_done_seen");
    tick();
    check_queues("t3");
    $display("burst base=%0h len=3 wrap: done", GB_END - 8'd1);

    // Zero-length start.
    tick();
    d0 = done_cnt;
    launch(8'h33, 0);
    @(negedge clk);
    check("t4_c0_en", 32'(gb_en_o), 32'd0);
    check("t4_c0_busy", 32'(busy_o), 32'd0);
    tick(); start_i = 1'b0;
    @(negedge clk);
    check("t4_done_pulse", 32'(done_o), 32'd1);
    check("t4_busy", 32'(busy_o), 32'd0);
    check("t4_c1_en", 32'(gb_en_o), 32'd0);
    tick();
    @(negedge clk);
    check("t4_done_low", 32'(done_o), 32'd0);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    $display("burst len=0: done");

    // Reset after two words of an 8-word burst, then a fresh 3-word burst.
    tick();
    push_burst(8'h80, 8);
    launch(8'h80, 8);
    tick(); start_i = 1'b0;
    tick();
    tick();
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    check_reset_outputs("t5_rst");
    tick();
    push_burst(8'h90, 3);
    d0 = done_cnt;
    launch(8'h90, 3);
    tick(); start_i = 1'b0;
    wait_done(20, "t5_done_seen");
    tick();
    @(negedge clk);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);
    check_queues("t5");
    $display("mid-burst reset + burst base=90 len=3: done");

    // start_i re-pulsed while busy must be ignored.
    tick();
    push_burst(8'h20, 5);
    d0 = done_cnt;
    launch(8'h20, 5);
    tick(); start_i = 1'b0;
    tick(); launch(8'hC0, 2);
    tick(); start_i = 1'b0;
    wait_done(30, "t6_done_seen");
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);
    check("t6_busy", 32'(busy_o), 32'd0);
    check_queues("t6");
    $display("burst base=20 len=5 with ignored restart: done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
